// File: rtl/shift_pkg.sv
// shift_pkg: shared op encodings, FSM states, step limit and bit reversal for shift_seq
package shift_pkg;
    localparam int STEP_MAX = 7;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    function automatic logic [31:0] bit_rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction
endpackage

// File: rtl/shift_step_32.sv
// shift_step_32: combinational left shift by a one-hot selected distance 0..STEP_MAX
//   din  : operand
//   s    : one-hot select, s[k] shifts by k
//   fill : value shifted into the vacated low bits
//   dout : shifted result
module shift_step_32 #(
    parameter int STEP_MAX = shift_pkg::STEP_MAX
) (
    input  logic [31:0]       din,
    input  logic [STEP_MAX:0] s,
    input  logic              fill,
    output logic [31:0]       dout
);
    import shift_pkg::*;
    always_comb begin
        dout = '0;
        for (int i = 0; i <= STEP_MAX; i++)
            dout = dout | (s[i] ? ((din << i) | ({32{fill}} & ((32'd1 << i) - 32'd1))) : 32'd0);
    end
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle SLL/SRL/SRA sequencer built on a small left-shift step
//   clk, rst_n                     : clock, async active-low reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_op, req_data, req_shamt    : operation, operand, shift amount
//   rsp_valid/rsp_ready, rsp_data  : registered response handshake and result
//   busy                           : operation in flight (SHIFT or DONE)
module shift_seq #(
    parameter int STEP_MAX = shift_pkg::STEP_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);
    import shift_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d, rsp_q, rsp_d, step_out;
    logic [4:0]  rem_q, rem_d, k, rem_nx;
    logic        fill_q, fill_d, dir_q, dir_d, req_right;
    logic [STEP_MAX:0] sel;

    assign k         = (rem_q > 5'(STEP_MAX)) ? 5'(STEP_MAX) : rem_q;
    assign rem_nx    = rem_q - k;
    // op 10 is not a defined encoding and is treated as a logical right shift
    assign req_right = (req_op == OP_SRL) || req_op[1];

    always_comb begin
        for (int i = 0; i <= STEP_MAX; i++) sel[i] = (k == 5'(i));
    end

    shift_step_32 #(.STEP_MAX(STEP_MAX)) u_step (
        .din  (acc_q),
        .s    (sel),
        .fill (fill_q),
        .dout (step_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        dir_d   = dir_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                // right shifts run as left shifts on the bit-reversed operand
                acc_d   = req_right ? bit_rev(req_data) : req_data;
                rem_d   = req_shamt;
                fill_d  = (req_op == OP_SRA) && req_data[31];
                dir_d   = req_right;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_d = step_out;
                rem_d = rem_nx;
                if (rem_nx == 5'd0) begin
                    rsp_d   = dir_q ? bit_rev(step_out) : step_out;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            dir_q   <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            dir_q   <= dir_d;
            rsp_q   <= rsp_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed and random checks of shift_seq against an arithmetic shift model
module tb_shift_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = '0;
    logic [4:0]  req_shamt = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    int checks = 0;
    int failures = 0;

    shift_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int sh);
        if (op == 2'b00) return d << sh;
        if (op == 2'b11) return 32'($signed(d) >>> sh);
        return d >> sh;
    endfunction

    function automatic int cycles(input int sh);
        return (sh == 0) ? 1 : (sh + 6) / 7;
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] d, input int sh, input int hold);
        logic [31:0] exp;
        int cnt;
        exp = model(op, d, sh);
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_shamt = 5'(sh);
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = $urandom;
        req_shamt = 5'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("shift_cycles", 32'(cnt), 32'(cycles(sh)));
        chk("rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, exp);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b00, 32'h0000_0001, 31, 0);
        do_op(2'b11, 32'h8000_0000, 8, 0);
        do_op(2'b01, 32'h8000_0000, 8, 0);
        do_op(2'b00, 32'hDEAD_BEEF, 0, 0);
        do_op(2'b11, 32'hDEAD_BEEF, 0, 0);
        do_op(2'b10, 32'hDEAD_BEEF, 0, 0);
        do_op(2'b00, 32'h0000_00FF, 4, 3);
        do_op(2'b00, 32'h0000_0001, 7, 0);
        do_op(2'b00, 32'h0000_0001, 8, 0);
        do_op(2'b00, 32'h0000_0001, 14, 0);
        do_op(2'b00, 32'h0000_0001, 15, 0);
        do_op(2'b10, 32'hF000_000F, 13, 1);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_data  = 32'h0000_0001;
        req_shamt = 5'd31;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b11, 32'h8765_4321, 19, 0);
        for (int n = 0; n < 24; n++)
            do_op(2'($urandom), $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
